// File: rtl/exc_pipe_if.sv
// Trap request channel from the exception pipeline to the CSR unit.
// The master raises trap_vld with a stable cause/tval until the slave accepts with trap_ready.
interface exc_pipe_if #(
  parameter int XLEN = 64
);
  logic            trap_vld;
  logic            trap_ready;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_val;

  modport master (
    output trap_vld,
    output trap_cause,
    output trap_val,
    input  trap_ready
  );

  modport slave (
    input  trap_vld,
    input  trap_cause,
    input  trap_val,
    output trap_ready
  );
endinterface

// File: rtl/exc_pipe.sv
// Exception/trap unit for the rv6 core.
// Each instruction's exception record travels through NSTG-1 registered stages. At the
// combinational commit stage that record is merged with any commit-stage exception and with
// pending interrupts. One trap per event is offered to the CSR unit, and the handshake is
// followed by a single-cycle flush of the whole pipeline.
module exc_pipe #(
  parameter int XLEN = 64,
  parameter int NSTG = 4,
  parameter int CW   = 6,
  parameter int NIRQ = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSTG-1:0]      inj_vld,
  input  logic [NSTG*CW-1:0]   inj_cause,
  input  logic [NSTG*XLEN-1:0] inj_val,
  input  logic [NSTG-2:0]      stall,
  input  logic [NSTG-2:0]      flush,
  input  logic                 commit_vld,
  input  logic [NIRQ-1:0]      irq_pend,
  input  logic                 irq_en,
  exc_pipe_if.master           trap,
  output logic                 t_flush,
  output logic                 busy
);

  localparam int NREG = NSTG - 1;
  localparam int IW   = $clog2(NIRQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Registered stage records, gathered for commit-stage access
  logic [NREG-1:0] stg_v;
  logic [CW-1:0]   stg_cause [NREG];
  logic [XLEN-1:0] stg_val   [NREG];

  // Commit-stage merge
  logic            sync_v;
  logic [CW-1:0]   sync_cause;
  logic [XLEN-1:0] sync_val;
  logic            irq_evt;
  logic            trap_evt;
  logic [IW-1:0]   irq_idx;
  logic [XLEN-1:0] evt_cause;
  logic [XLEN-1:0] evt_val;

  // Latched trap presented to the CSR unit
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] val_q;

  // Interrupt lines that take part in the fixed-priority chain
  function automatic logic is_fixed(input int n);
    return (n == 11) || (n == 3) || (n == 7) || (n == 9) || (n == 1) || (n == 5);
  endfunction

  // Interrupt selection: 11 > 3 > 7 > 9 > 1 > 5, then the other lines, lowest index first
  function automatic logic [IW-1:0] irq_pick(input logic [NIRQ-1:0] p);
    logic [IW-1:0] idx;
    idx = '0;
    for (int n = NIRQ - 1; n >= 0; n--) begin
      if (p[n] && !is_fixed(n)) idx = IW'(n);
    end
    if (p[5])  idx = IW'(5);
    if (p[1])  idx = IW'(1);
    if (p[9])  idx = IW'(9);
    if (p[7])  idx = IW'(7);
    if (p[3])  idx = IW'(3);
    if (p[11]) idx = IW'(11);
    return idx;
  endfunction

  // ---- Registered stages 0..NSTG-2 ----
  for (genvar g = 0; g < NREG; g++) begin : g_stg
    logic            v;
    logic [CW-1:0]   cause;
    logic [XLEN-1:0] val;
    logic            cv;
    logic [CW-1:0]   cc;
    logic [XLEN-1:0] cvl;

    if (g == 0) begin : g_first
      assign cv  = 1'b0;
      assign cc  = '0;
      assign cvl = '0;
    end else begin : g_rest
      assign cv  = stg_v[g-1];
      assign cc  = stg_cause[g-1];
      assign cvl = stg_val[g-1];
    end

    // Valid bit: reset/trap flush, then branch squash, then carry-or-inject, else capture while stalled
    always_ff @(posedge clk) begin
      if (rst || t_flush || flush[g]) begin
        v <= 1'b0;
      end else if (!stall[g]) begin
        v <= cv | inj_vld[g];
      end else if (!v && inj_vld[g]) begin
        v <= 1'b1;
      end
    end

    // Payload: the older, carried exception wins over a new injection; contents are don't-care while v=0
    always_ff @(posedge clk) begin
      if (!stall[g]) begin
        if (cv) begin
          cause <= cc;
          val   <= cvl;
        end else begin
          cause <= inj_cause[g*CW +: CW];
          val   <= inj_val[g*XLEN +: XLEN];
        end
      end else if (!v) begin
        cause <= inj_cause[g*CW +: CW];
        val   <= inj_val[g*XLEN +: XLEN];
      end
    end

    assign stg_v[g]     = v;
    assign stg_cause[g] = cause;
    assign stg_val[g]   = val;
  end

  // ---- Commit stage (combinational) ----
  // Pick the synchronous exception: the carried record if present, otherwise a commit-stage injection
  always_comb begin
    sync_v     = stg_v[NREG-1] | inj_vld[NSTG-1];
    sync_cause = inj_cause[(NSTG-1)*CW +: CW];
    sync_val   = inj_val[(NSTG-1)*XLEN +: XLEN];
    if (stg_v[NREG-1]) begin
      sync_cause = stg_cause[NREG-1];
      sync_val   = stg_val[NREG-1];
    end
  end

  assign irq_evt  = commit_vld && irq_en && (|irq_pend);
  assign trap_evt = commit_vld && (irq_evt || sync_v);
  assign irq_idx  = irq_pick(irq_pend);

  // Build the mcause/tval pair for this cycle's event; interrupts take precedence over exceptions
  always_comb begin
    evt_cause = '0;
    evt_val   = '0;
    if (irq_evt) begin
      evt_cause[XLEN-1]  = 1'b1;
      evt_cause[IW-1:0]  = irq_idx;
    end else begin
      evt_cause[CW-1:0]  = sync_cause;
      evt_val            = sync_val;
    end
  end

  // ---- Trap FSM ----
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept one event in IDLE, hold in REQ until accepted, flush for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trap_evt)        state_nxt = REQ;
      REQ:     if (trap.trap_ready) state_nxt = FLUSH;
      FLUSH:                        state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Capture the trap only when leaving IDLE so cause/tval stay stable throughout REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      val_q   <= '0;
    end else if (state == IDLE && trap_evt) begin
      cause_q <= evt_cause;
      val_q   <= evt_val;
    end
  end

  assign trap.trap_vld   = (state == REQ);
  assign trap.trap_cause = cause_q;
  assign trap.trap_val   = val_q;
  assign t_flush         = (state == FLUSH);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_exc_pipe.sv
// Testbench for exc_pipe: a table of single-trap vectors plus hand-written multi-cycle sequences.
// Expected traps go into a queue when stimulus is driven and are popped when trap_vld rises.
module tb_exc_pipe;
  localparam int XLEN = 64;
  localparam int NSTG = 4;
  localparam int CW   = 6;
  localparam int NIRQ = 16;

  logic                 clk;
  logic                 rst;
  logic [NSTG-1:0]      inj_vld;
  logic [NSTG*CW-1:0]   inj_cause;
  logic [NSTG*XLEN-1:0] inj_val;
  logic [NSTG-2:0]      stall;
  logic [NSTG-2:0]      flush;
  logic                 commit_vld;
  logic [NIRQ-1:0]      irq_pend;
  logic                 irq_en;
  logic                 t_flush;
  logic                 busy;

  exc_pipe_if #(.XLEN(XLEN)) tif ();

  exc_pipe #(.XLEN(XLEN), .NSTG(NSTG), .CW(CW), .NIRQ(NIRQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .inj_vld   (inj_vld),
    .inj_cause (inj_cause),
    .inj_val   (inj_val),
    .stall     (stall),
    .flush     (flush),
    .commit_vld(commit_vld),
    .irq_pend  (irq_pend),
    .irq_en    (irq_en),
    .trap      (tif),
    .t_flush   (t_flush),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              stg;
    logic [CW-1:0]   cause;
    logic [XLEN-1:0] val;
    logic [NIRQ-1:0] irq;
    logic            ien;
    logic [XLEN-1:0] ecause;
    logic [XLEN-1:0] eval;
    int              lat;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] c;
    logic [XLEN-1:0] v;
  } exp_t;

  vec_t vecs[13];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    inj_vld   = '0;
    inj_cause = '0;
    inj_val   = '0;
    stall     = '0;
    flush     = '0;
    irq_pend  = '0;
    irq_en    = 1'b0;
  endtask

  task automatic drive_inj(input int s, input logic [CW-1:0] c, input logic [XLEN-1:0] v);
    inj_vld[s]             = 1'b1;
    inj_cause[s*CW +: CW]  = c;
    inj_val[s*XLEN +: XLEN] = v;
  endtask

  // Wait (bounded) for trap_vld, compare against the scoreboard, then handshake and check the flush pulse
  task automatic await_trap(input string nm, output int cyc);
    exp_t e;
    cyc = 0;
    do begin
      @(negedge clk);
      clear_in();
      cyc++;
    end while (!tif.trap_vld && cyc < 20);
    total++;
    if (!tif.trap_vld) begin
      bad++;
      $display("FAIL %s_timeout: got trap_vld=0 want 1 within 20 cycles", nm);
    end
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got empty scoreboard want one entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_cause"}, tif.trap_cause, e.c);
      chk({nm, "_val"}, tif.trap_val, e.v);
    end
    tif.trap_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_tflush"}, XLEN'(t_flush), 1);
    chk({nm, "_vld_after_hs"}, XLEN'(tif.trap_vld), 0);
    tif.trap_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_tflush_once"}, XLEN'(t_flush), 0);
    chk({nm, "_idle"}, XLEN'(busy), 0);
  endtask

  task automatic run_vec(input int i);
    int cyc;
    if (vecs[i].stg >= 0) drive_inj(vecs[i].stg, vecs[i].cause, vecs[i].val);
    irq_pend = vecs[i].irq;
    irq_en   = vecs[i].ien;
    sbq.push_back('{vecs[i].ecause, vecs[i].eval});
    await_trap($sformatf("vec%0d", i), cyc);
    chk($sformatf("vec%0d_lat", i), XLEN'(cyc), XLEN'(vecs[i].lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    exp_t e;

    //          stg cause  val                     irq       ien   exp cause               exp val                 lat
    vecs[0]  = '{0,  6'd1,  64'h8000_0000,          16'h0000, 1'b0, 64'h1,                  64'h8000_0000,          4};
    vecs[1]  = '{1,  6'd2,  64'h1234,               16'h0000, 1'b0, 64'h2,                  64'h1234,               3};
    vecs[2]  = '{2,  6'd13, 64'hdead_beef_cafe_f00d, 16'h0000, 1'b0, 64'hd,                  64'hdead_beef_cafe_f00d, 2};
    vecs[3]  = '{3,  6'd5,  64'h55,                 16'h0000, 1'b0, 64'h5,                  64'h55,                 1};
    vecs[4]  = '{3,  6'd4,  64'h99,                 16'h0088, 1'b1, 64'h8000_0000_0000_0003, 64'h0,                  1};
    vecs[5]  = '{-1, 6'd0,  64'h0,                  16'h0808, 1'b1, 64'h8000_0000_0000_000b, 64'h0,                  1};
    vecs[6]  = '{-1, 6'd0,  64'h0,                  16'h0022, 1'b1, 64'h8000_0000_0000_0001, 64'h0,                  1};
    vecs[7]  = '{-1, 6'd0,  64'h0,                  16'h1001, 1'b1, 64'h8000_0000_0000_0000, 64'h0,                  1};
    vecs[8]  = '{-1, 6'd0,  64'h0,                  16'h0024, 1'b1, 64'h8000_0000_0000_0005, 64'h0,                  1};
    vecs[9]  = '{3,  6'd7,  64'h77,                 16'h0080, 1'b0, 64'h7,                  64'h77,                 1};
    vecs[10] = '{-1, 6'd0,  64'h0,                  16'h0280, 1'b1, 64'h8000_0000_0000_0007, 64'h0,                  1};
    vecs[11] = '{-1, 6'd0,  64'h0,                  16'hc000, 1'b1, 64'h8000_0000_0000_000e, 64'h0,                  1};
    vecs[12] = '{0,  6'd63, 64'hffff_ffff_ffff_ffff, 16'h0000, 1'b0, 64'h3f,                 64'hffff_ffff_ffff_ffff, 4};

    rst = 1'b1;
    commit_vld = 1'b1;
    tif.trap_ready = 1'b0;
    clear_in();
    repeat (3) @(negedge clk);
    chk("rst_trap_vld", XLEN'(tif.trap_vld), 0);
    chk("rst_t_flush", XLEN'(t_flush), 0);
    chk("rst_busy", XLEN'(busy), 0);
    chk("rst_cause", tif.trap_cause, 0);
    chk("rst_val", tif.trap_val, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(i);

    // Older exception wins over a later injection for the same instruction
    drive_inj(0, 6'd2, 64'h200);
    sbq.push_back('{64'h2, 64'h200});
    @(negedge clk);
    clear_in();
    @(negedge clk);
    drive_inj(2, 6'd5, 64'h500);
    await_trap("older_wins", cyc);

    // REQ holds: outputs stable, new commit-stage exception ignored
    drive_inj(3, 6'd3, 64'habc);
    sbq.push_back('{64'h3, 64'habc});
    @(negedge clk);
    clear_in();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_vld", k), XLEN'(tif.trap_vld), 1);
      chk($sformatf("hold%0d_cause", k), tif.trap_cause, 64'h3);
      chk($sformatf("hold%0d_val", k), tif.trap_val, 64'habc);
      chk($sformatf("hold%0d_busy", k), XLEN'(busy), 1);
      clear_in();
      if (k == 1) drive_inj(3, 6'd6, 64'h666);
      @(negedge clk);
    end
    await_trap("hold", cyc);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_gone%0d", k), XLEN'(tif.trap_vld), 0);
      @(negedge clk);
    end

    // trap_ready outside REQ does nothing
    tif.trap_ready = 1'b1;
    @(negedge clk);
    tif.trap_ready = 1'b0;
    chk("rdy_idle_busy", XLEN'(busy), 0);
    chk("rdy_idle_tflush", XLEN'(t_flush), 0);

    // Branch squash on stage 1 beats both the carried record and a new injection
    drive_inj(0, 6'd8, 64'h800);
    @(negedge clk);
    clear_in();
    flush[1] = 1'b1;
    drive_inj(1, 6'd9, 64'h901);
    @(negedge clk);
    clear_in();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("squash%0d_vld", k), XLEN'(tif.trap_vld), 0);
      chk($sformatf("squash%0d_busy", k), XLEN'(busy), 0);
      @(negedge clk);
    end

    // Stalled empty stage captures an injection, then holds it against a second injection
    stall[1] = 1'b1;
    drive_inj(1, 6'd9, 64'h900);
    sbq.push_back('{64'h9, 64'h900});
    @(negedge clk);
    clear_in();
    stall[1] = 1'b1;
    drive_inj(1, 6'd10, 64'ha00);
    @(negedge clk);
    clear_in();
    await_trap("stall_cap", cyc);

    // Reset while in REQ drops the trap without a flush
    drive_inj(3, 6'd4, 64'h44);
    @(negedge clk);
    clear_in();
    chk("rstreq_pre_vld", XLEN'(tif.trap_vld), 1);
    chk("rstreq_pre_cause", tif.trap_cause, 64'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstreq_vld", XLEN'(tif.trap_vld), 0);
    chk("rstreq_busy", XLEN'(busy), 0);
    chk("rstreq_tflush", XLEN'(t_flush), 0);
    @(negedge clk);
    chk("rstreq_no_flush", XLEN'(t_flush), 0);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
